// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types, slot states and select mapping for the seven-segment scanner
package seven_seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;
  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] nibble_t;
  // The decoder's digit select is wired bit-reversed relative to the scan index
  function automatic logic [2:0] idx_to_sel(input digit_idx_t idx);
    return {idx[0], idx[1], idx[2]};
  endfunction
endpackage

// File: rtl/seg_next_digit.sv
// seg_next_digit: cyclic priority search for the next enabled digit after idx_i
module seg_next_digit
  import seven_seg_pkg::*;
(
  input  digit_idx_t            idx_i,
  input  logic [NUM_DIGITS-1:0] mask_i,
  output digit_idx_t            nxt_o,
  output logic                  wrap_o
);
  always_comb begin
    digit_idx_t cand;
    logic found;
    nxt_o = idx_i;
    found = 1'b0;
    cand  = idx_i;
    // k = NUM_DIGITS lands back on idx_i, so a lone enabled digit reselects itself
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      cand = idx_i + digit_idx_t'(k);
      if (!found && mask_i[cand]) begin
        nxt_o = cand;
        found = 1'b1;
      end
    end
  end
  assign wrap_o = nxt_o <= idx_i;
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: double-buffered 8-digit time-multiplexed scan with anti-ghost blanking
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GHOST       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  digit_en,
  output logic [2:0]  sel,
  output logic [3:0]  num,
  output logic        dp_n,
  output logic        blank,
  output logic        frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d, nxt;
  logic [31:0]   active_data_q, active_data_d, shadow_data_q, shadow_data_d;
  logic [7:0]    active_dp_q, active_dp_d, shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d, live_q, live_d;
  logic          slot_end, wrap, accept, xfer;
  logic [0:0]    state;
  seg_next_digit u_next (
    .idx_i  (idx_q),
    .mask_i (digit_en),
    .nxt_o  (nxt),
    .wrap_o (wrap)
  );
  assign slot_end   = cnt_q == CW'(REFRESH_DIV - 1);
  assign frame_done = slot_end & wrap;
  assign load_ready = ~pending_q;
  assign accept     = load_valid & ~pending_q;
  assign xfer       = frame_done & pending_q;
  assign cnt_d         = slot_end ? '0 : cnt_q + 1'b1;
  assign idx_d         = slot_end ? nxt : idx_q;
  // live_q remembers whether the digit chosen at the last slot end was actually enabled
  assign live_d        = slot_end ? |digit_en : live_q;
  assign shadow_data_d = accept ? load_data : shadow_data_q;
  assign shadow_dp_d   = accept ? load_dp : shadow_dp_q;
  assign active_data_d = xfer ? shadow_data_q : active_data_q;
  assign active_dp_d   = xfer ? shadow_dp_q : active_dp_q;
  assign pending_d     = accept | (pending_q & ~xfer);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      live_q        <= 1'b1;
      active_data_q <= '0;
      active_dp_q   <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      live_q        <= live_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
    end
  end
  assign state = cnt_q < CW'(GHOST) ? ST_BLANK : ST_SHOW;
  assign blank = (state == ST_BLANK) | ~live_q;
  assign sel   = idx_to_sel(idx_q);
  assign num   = active_data_q[4*idx_q +: 4];
  assign dp_n  = blank | ~active_dp_q[idx_q];
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed and random checks against a slot-level reference model
module tb_seven_seg_scan_ctrl;
  localparam int RD = 8;
  localparam int GH = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic [7:0]  load_dp = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic [2:0]  sel;
  logic [3:0]  num;
  logic        dp_n, blank, frame_done;
  int errors = 0;
  int checks = 0;
  int m_idx, m_cnt;
  bit m_live, m_pend;
  logic [31:0] m_act, m_sh;
  logic [7:0]  m_adp, m_sdp;
  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .GHOST(GH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .digit_en   (digit_en),
    .sel        (sel),
    .num        (num),
    .dp_n       (dp_n),
    .blank      (blank),
    .frame_done (frame_done)
  );
  always #5 clk = ~clk;
  function automatic int next_digit(input int idx, input logic [7:0] en);
    for (int k = 1; k <= 8; k++)
      if (en[(idx + k) % 8]) return (idx + k) % 8;
    return idx;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (idx=%0d cnt=%0d)", tag, obs, exp, m_idx, m_cnt);
    end
  endtask
  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_live = 1; m_pend = 0;
    m_act = 0; m_sh = 0; m_adp = 0; m_sdp = 0;
  endtask
  task automatic tick();
    int nx;
    bit e_blank, e_fd;
    @(negedge clk);
    nx      = next_digit(m_idx, digit_en);
    e_blank = (m_cnt < GH) || !m_live;
    e_fd    = (m_cnt == RD - 1) && (nx <= m_idx);
    chk("sel", 32'(sel), 32'(((m_idx % 2) * 4) + (((m_idx / 2) % 2) * 2) + (m_idx / 4)));
    chk("num", 32'(num), (m_act >> (4 * m_idx)) & 32'hF);
    chk("blank", 32'(blank), 32'(e_blank));
    chk("dp_n", 32'(dp_n), e_blank ? 32'd1 : 32'(!m_adp[m_idx]));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("load_ready", 32'(load_ready), 32'(!m_pend));
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      bit acc;
      acc = load_valid && !m_pend;
      if (e_fd && m_pend) begin m_act = m_sh; m_adp = m_sdp; m_pend = 0; end
      if (acc) begin m_sh = load_data; m_sdp = load_dp; m_pend = 1; end
      if (m_cnt == RD - 1) begin m_cnt = 0; m_live = digit_en != 0; m_idx = nx; end
      else m_cnt++;
    end
    #1;
  endtask
  initial begin
    int n;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_sel", 32'(sel), 0);
    chk("reset_blank", 32'(blank), 1);
    rst_n = 1'b1;
    // Known frame: digit k shows k, decimal point on digit 0
    load_valid = 1'b1; load_data = 32'h76543210; load_dp = 8'h01;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 2 * 8 * RD; i++) tick();
    chk("frame_shown", m_act, 32'h76543210);
    digit_en = 8'h81;
    for (int i = 0; i < 8 * RD; i++) tick();
    // Back-to-back A then B with valid held
    digit_en = 8'hFF;
    load_valid = 1'b1; load_data = 32'hAAAA5555; load_dp = 8'hF0;
    tick();
    load_data = 32'h0F1E2D3C; load_dp = 8'h3C;
    n = 0;
    while (m_pend && n < 200) begin tick(); n++; end
    chk("b_accept_bound", 32'(m_pend), 0);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 2 * 8 * RD; i++) tick();
    // All digits disabled with a pending load
    load_valid = 1'b1; load_data = 32'h13572468; load_dp = 8'h55;
    tick();
    load_valid = 1'b0; digit_en = 8'h00;
    for (int i = 0; i < 5 * RD; i++) tick();
    chk("pend_cleared", 32'(load_ready), 1);
    // Reset at cnt 5 of idx 3 with a load pending
    digit_en = 8'hFF;
    n = 0;
    while (!(m_idx == 0 && m_cnt == 0) && n < 200) begin tick(); n++; end
    load_valid = 1'b1; load_data = 32'hDEADBEEF; load_dp = 8'hFF;
    tick();
    load_valid = 1'b0;
    n = 0;
    while (!(m_idx == 3 && m_cnt == 5) && n < 200) begin tick(); n++; end
    chk("reach_idx3_cnt5", 32'(m_idx * 8 + m_cnt), 29);
    chk("pending_before_rst", 32'(load_ready), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_ready", 32'(load_ready), 1);
    for (int i = 0; i < 3 * 8 * RD; i++) tick();
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = $urandom;
      load_dp    = 8'($urandom);
      if ($urandom_range(0, 31) == 0) digit_en = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
